// File: rtl/fifo_multilane.sv
// Multi-lane circular FIFO between fetch/decode and rename/dispatch.
// Enqueues and dequeues up to LANES entries per cycle, with flush, occupancy and almost-full.
module fifo_multilane #(
  parameter int DEPTH       = 3,
  parameter int WIDTH       = 32,
  parameter int LANES       = 2,
  parameter int ALMOST_FULL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [LANES-1:0]       valid_i,
  output logic                   ready_i,
  input  logic [LANES*WIDTH-1:0] data_i,
  output logic [LANES-1:0]       valid_o,
  input  logic [LANES-1:0]       ready_o,
  output logic [LANES*WIDTH-1:0] data_o,
  output logic [DEPTH:0]         count_o,
  output logic                   almost_full_o
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam int CW      = DEPTH + 2;
  localparam logic [CW-1:0] ENTRIES_W = CW'(ENTRIES);
  localparam logic [CW-1:0] LANES_W   = CW'(LANES);
  localparam logic [CW-1:0] AF_W      = CW'(ALMOST_FULL);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   count_q, count_d;

  logic [CW-1:0]    count_w;
  logic [CW-1:0]    free_w;
  logic [CW-1:0]    count_sum;
  logic [CW-1:0]    n_in;
  logic [CW-1:0]    n_out;
  logic             in_run;
  logic             out_run;

  always_comb begin
    count_w       = {1'b0, count_q};
    free_w        = ENTRIES_W - count_w;
    ready_i       = (free_w >= LANES_W);
    almost_full_o = (free_w <= AF_W);
    count_o       = count_q;

    valid_o = '0;
    data_o  = '0;
    for (int k = 0; k < LANES; k++) begin
      valid_o[k]                = (count_w > CW'(k));
      data_o[k*WIDTH +: WIDTH]  = mem_q[rd_ptr_q + DEPTH'(k)];
    end

    // Only a leading run of asserted lanes counts; a hole stops the run.
    n_in   = '0;
    in_run = ready_i;
    for (int k = 0; k < LANES; k++) begin
      if (in_run && valid_i[k]) n_in = n_in + CW'(1);
      else                      in_run = 1'b0;
    end

    n_out   = '0;
    out_run = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (out_run && valid_o[k] && ready_o[k]) n_out = n_out + CW'(1);
      else                                     out_run = 1'b0;
    end

    mem_d = mem_q;
    if (!flush_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (CW'(k) < n_in) mem_d[wr_ptr_q + DEPTH'(k)] = data_i[k*WIDTH +: WIDTH];
      end
    end

    count_sum = count_w + n_in - n_out;
    count_d   = count_sum[DEPTH:0];
    wr_ptr_d  = wr_ptr_q + n_in[DEPTH-1:0];
    rd_ptr_d  = rd_ptr_q + n_out[DEPTH-1:0];

    // Flush drops same-cycle traffic and returns the pointers to their reset position.
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
